// File: rtl/schmitt_filter_pkg.sv
// Shared defaults and the per-channel output state type for the Schmitt filter bank.
package schmitt_filter_pkg;

  localparam int DEF_NCH         = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_HI_TH       = 12;
  localparam int DEF_LO_TH       = 3;
  localparam int DEF_PRESCALE    = 1;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } sch_state_e;

endpackage

// File: rtl/schmitt_filter_ch.sv
// One filter channel: synchroniser, saturating up/down integrator, LOW/HIGH hysteresis
// state machine and registered edge pulses.
module schmitt_filter_ch
  import schmitt_filter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HI_TH       = DEF_HI_TH,
  parameter int LO_TH       = DEF_LO_TH
) (
  input  logic clk,
  input  logic clear,
  input  logic tick,
  input  logic pad_in,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HI_V    = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_V    = CNT_W'(LO_TH);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  sch_state_e             state_q, state_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
    cnt_d  = cnt_q;
    if (tick) begin
      if (sync_bit && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!sync_bit && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Thresholds act on the registered count, so the pulse and the level change together.
  always_comb begin
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (cnt_q >= HI_V) begin
          state_d = ST_HIGH;
          rise_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q <= LO_V) begin
          state_d = ST_LOW;
          fall_d  = 1'b1;
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_LOW;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign filt_out   = (state_q == ST_HIGH);
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/schmitt_filter_bank.sv
// NCH-channel digital Schmitt filter bank with shared prescaler and power-good clear.
// Optional sticky edge status / interrupt enabled by defining SCHMITT_FILTER_IRQ_EN.
module schmitt_filter_bank
  import schmitt_filter_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HI_TH       = DEF_HI_TH,
  parameter int LO_TH       = DEF_LO_TH,
  parameter int PRESCALE    = DEF_PRESCALE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pwr_good,
  input  logic [NCH-1:0] pad_in,
  output logic [NCH-1:0] filt_out,
  output logic [NCH-1:0] rise_pulse,
  output logic [NCH-1:0] fall_pulse,
  input  logic [NCH-1:0] irq_clr,
  output logic [NCH-1:0] irq_status,
  output logic           irq
);

  if (!((LO_TH < HI_TH) && (HI_TH <= (2**CNT_W) - 1))) begin : g_err_th
    $error("schmitt_filter_bank: thresholds must satisfy LO_TH < HI_TH <= 2**CNT_W-1");
  end
  if (PRESCALE < 1) begin : g_err_ps
    $error("schmitt_filter_bank: PRESCALE must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("schmitt_filter_bank: SYNC_STAGES must be at least 2");
  end

  // Power loss behaves exactly like reset for every register in the bank.
  logic clear;
  logic tick;

  assign clear = reset | ~pwr_good;

  if (PRESCALE > 1) begin : g_ps
    localparam int PS_W = $clog2(PRESCALE);
    logic [PS_W-1:0] ps_q, ps_d;

    always_comb begin
      ps_d = (ps_q == PS_W'(PRESCALE - 1)) ? '0 : ps_q + PS_W'(1);
    end

    always_ff @(posedge clk) begin
      if (clear) begin
        ps_q <= '0;
      end else begin
        ps_q <= ps_d;
      end
    end

    assign tick = (ps_q == '0);
  end else begin : g_no_ps
    assign tick = 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    schmitt_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .HI_TH       (HI_TH),
      .LO_TH       (LO_TH)
    ) u_ch (
      .clk        (clk),
      .clear      (clear),
      .tick       (tick),
      .pad_in     (pad_in[i]),
      .filt_out   (filt_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

`ifdef SCHMITT_FILTER_IRQ_EN
  logic [NCH-1:0] status_q, status_d;
  logic           irq_q, irq_d;

  // A new edge outranks a clear landing in the same cycle, so no event is lost.
  always_comb begin
    status_d = (status_q & ~irq_clr) | rise_pulse | fall_pulse;
    irq_d    = |status_d;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_status = status_q;
  assign irq        = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = ^irq_clr;
  assign irq_status     = '0;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_schmitt_filter_bank.sv
// Self-checking bench for schmitt_filter_bank: behavioural model compared every cycle,
// directed latency/glitch/hysteresis/saturation/power-good/IRQ checks, plus random traffic.
module tb_schmitt_filter_bank;

  localparam int NCH      = 4;
  localparam int SYNC     = 2;
  localparam int CNT_MAX  = 15;
  localparam int HI_TH    = 12;
  localparam int LO_TH    = 3;
  localparam int PRESCALE = 1;

  logic           clk;
  logic           reset;
  logic           pwr_good;
  logic [NCH-1:0] pad_in;
  logic [NCH-1:0] irq_clr;
  logic [NCH-1:0] filt_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;
  logic [NCH-1:0] irq_status;
  logic           irq;

  logic [NCH-1:0] pad4;
  logic [NCH-1:0] filt4;
  logic [NCH-1:0] rise4;
  logic [NCH-1:0] unused_fall4;
  logic [NCH-1:0] unused_status4;
  logic           unused_irq4;

  int checks   = 0;
  int failures = 0;

  schmitt_filter_bank dut (
    .clk        (clk),
    .reset      (reset),
    .pwr_good   (pwr_good),
    .pad_in     (pad_in),
    .filt_out   (filt_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq_clr    (irq_clr),
    .irq_status (irq_status),
    .irq        (irq)
  );

  schmitt_filter_bank #(.PRESCALE(4)) dut_p4 (
    .clk        (clk),
    .reset      (reset),
    .pwr_good   (pwr_good),
    .pad_in     (pad4),
    .filt_out   (filt4),
    .rise_pulse (rise4),
    .fall_pulse (unused_fall4),
    .irq_clr    ('0),
    .irq_status (unused_status4),
    .irq        (unused_irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive a pad pattern from the next falling edge and hold it for the given number of clocks.
  task automatic applyStimulus(input logic [NCH-1:0] pad, input int cycles);
    @(negedge clk);
    pad_in = pad;
    repeat (cycles) @(posedge clk);
  endtask

  // Count rising edges (first one = 0) until filt_out[ch] reaches level; bounded.
  task automatic waitFilt(input int ch, input logic level, output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (filt_out[ch] === level) break;
      n++;
      if (n >= 200) begin
        $display("[TB] FAIL wait_filt ch%0d timeout", ch);
        break;
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] pad_hist[$];
  int             m_cnt[NCH];
  int             m_ps;
  logic [NCH-1:0] m_filt, m_rise, m_fall, m_status;
  logic           m_irq;
  logic           m_valid = 1'b0;

  always @(posedge clk) begin
    logic [NCH-1:0] seen;
    logic [NCH-1:0] old_pulse;
    logic           tick;
    int             c;
    if (reset || !pwr_good) begin
      pad_hist.delete();
      for (int s = 0; s < SYNC; s++) pad_hist.push_back('0);
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_ps = 0;
      m_filt = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;
    end else begin
      seen = pad_hist.pop_front();
      pad_hist.push_back(pad_in);
      tick = (m_ps == 0);
      m_ps = (m_ps + 1) % PRESCALE;
      old_pulse = m_rise | m_fall;
      for (int i = 0; i < NCH; i++) begin
        c = m_cnt[i];
        m_rise[i] = !m_filt[i] && (c >= HI_TH);
        m_fall[i] = m_filt[i] && (c <= LO_TH);
        if (m_rise[i]) m_filt[i] = 1'b1;
        if (m_fall[i]) m_filt[i] = 1'b0;
        if (tick) m_cnt[i] = seen[i] ? ((c + 1 > CNT_MAX) ? CNT_MAX : c + 1)
                                     : ((c - 1 < 0) ? 0 : c - 1);
      end
`ifdef SCHMITT_FILTER_IRQ_EN
      m_status = (m_status & ~irq_clr) | old_pulse;
      m_irq    = |m_status;
`else
      m_status = '0;
      m_irq    = 1'b0;
      if (old_pulse == '1) m_irq = 1'b0;
`endif
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_filt", 32'(filt_out), 32'(m_filt));
      checkOutput("model_rise", 32'(rise_pulse), 32'(m_rise));
      checkOutput("model_fall", 32'(fall_pulse), 32'(m_fall));
      checkOutput("model_status", 32'(irq_status), 32'(m_status));
      checkOutput("model_irq", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int hold;
    reset    = 1'b1;
    pwr_good = 1'b1;
    pad_in   = '1;
    irq_clr  = '0;
    pad4     = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_filt", 32'(filt_out), 32'h0);
    checkOutput("reset_rise", 32'(rise_pulse), 32'h0);
    checkOutput("reset_fall", 32'(fall_pulse), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);

    @(negedge clk);
    reset = 1'b0;
    waitFilt(0, 1'b1, n);
    checkOutput("release_latency", 32'(n), 32'd14);
    checkOutput("release_filt_all", 32'(filt_out), 32'hF);
    checkOutput("release_rise_all", 32'(rise_pulse), 32'hF);

    @(negedge clk);
    pwr_good = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("pwrgood_filt", 32'(filt_out), 32'h0);
    checkOutput("pwrgood_pulses", 32'(rise_pulse | fall_pulse), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    pwr_good = 1'b1;
    pad_in   = '0;
    repeat (5) @(posedge clk);

    @(negedge clk);
    pad_in = 4'b0001;
    waitFilt(0, 1'b1, n);
    checkOutput("rise_latency", 32'(n), 32'd14);
    checkOutput("rise_pulse_on", 32'(rise_pulse), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("rise_pulse_off", 32'(rise_pulse), 32'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    pad_in = 4'b0000;
    waitFilt(0, 1'b0, n);
    checkOutput("fall_latency", 32'(n), 32'd14);
    checkOutput("fall_pulse_on", 32'(fall_pulse), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("fall_pulse_off", 32'(fall_pulse), 32'h0);
    repeat (20) @(posedge clk);

    applyStimulus(4'b0010, 5);
    applyStimulus(4'b0000, 30);
    #1;
    checkOutput("glitch_rejected", 32'(filt_out), 32'h0);

    applyStimulus(4'b0010, 30);
    #1;
    checkOutput("hyst_settled_high", 32'(filt_out), 32'h2);
    applyStimulus(4'b0000, 10);
    applyStimulus(4'b0010, 20);
    #1;
    checkOutput("hyst_held_high", 32'(filt_out), 32'h2);

    applyStimulus(4'b1010, 100);
    #1;
    checkOutput("saturation_high", 32'(filt_out), 32'hA);

    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      pad_in   = NCH'($urandom);
      irq_clr  = NCH'($urandom);
      pwr_good = ($urandom_range(0, 9) != 0);
      hold     = $urandom_range(1, 25);
      repeat (hold) @(posedge clk);
    end
    @(negedge clk);
    pwr_good = 1'b1;
    irq_clr  = '0;
    pad_in   = '0;
    repeat (20) @(posedge clk);

    @(negedge clk);
    pad4 = 4'b0001;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (filt4[0] === 1'b1) break;
      n++;
      if (n >= 200) begin
        $display("[TB] FAIL p4_wait timeout");
        break;
      end
    end
    checkOutput("p4_latency_window", 32'((n >= 47) && (n <= 53)), 32'h1);
    checkOutput("p4_filt", 32'(filt4), 32'h1);
    checkOutput("p4_rise", 32'(rise4), 32'h1);

`ifdef SCHMITT_FILTER_IRQ_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    pad_in = 4'b0100;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rise_pulse[2] === 1'b1) break;
      n++;
      if (n >= 200) begin
        $display("[TB] FAIL irq_rise timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("irq_status_set", 32'(irq_status), 32'h4);
    checkOutput("irq_set", 32'(irq), 32'h1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    pad_in = 4'b0000;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (fall_pulse[2] === 1'b1) break;
      n++;
      if (n >= 200) begin
        $display("[TB] FAIL irq_fall timeout");
        break;
      end
    end
    irq_clr = 4'b0100;
    @(posedge clk);
    #1;
    checkOutput("irq_set_wins", 32'(irq_status), 32'h4);
    @(posedge clk);
    #1;
    checkOutput("irq_cleared", 32'(irq_status), 32'h0);
    checkOutput("irq_cleared_out", 32'(irq), 32'h0);
    irq_clr = '0;
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
